// File: rtl/ref_win_mem_if.sv
// ---------------------------------------------------------------------------
// ref_win_mem_if
//   Bundles the reference-window row buffer's write, pop, read and status
//   signals into one interface. clk and rst stay plain ports on the design.
//
//   master : the reference fetch and SAD-array side (drives requests)
//   slave  : the row buffer itself (drives read results and status)
//
//   Signals
//     flush      m->s  clear the buffer (pointers and count)
//     wr_valid   m->s  row write request
//     wr_ready   s->m  high while the buffer is not full
//     wr_data    m->s  row pixels, pixel 0 in the LSBs
//     row_pop    m->s  retire the oldest row
//     rd_req     m->s  read request
//     rd_mode    m->s  0 = single row, 1 = NR-row burst
//     rd_offset  m->s  first row, relative to the oldest stored row
//     rd_data    s->m  read result, row i at bits [(i+1)*RW-1 : i*RW]
//     rd_valid   s->m  one-cycle pulse, rd_data valid
//     rd_err     s->m  one-cycle pulse, read out of range
//     count      s->m  rows stored
//     full       s->m  count == DEPTH
//     empty      s->m  count == 0
// ---------------------------------------------------------------------------
interface ref_win_mem_if #(
  parameter int PIXEL = 8,
  parameter int X     = 32,
  parameter int DEPTH = 64,
  parameter int NR    = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = PIXEL * X;

  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [RW-1:0]     wr_data;
  logic              row_pop;
  logic              rd_req;
  logic              rd_mode;
  logic [AW-1:0]     rd_offset;
  logic [NR*RW-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic [AW:0]       count;
  logic              full;
  logic              empty;

  modport master (
    output flush, wr_valid, wr_data, row_pop, rd_req, rd_mode, rd_offset,
    input  wr_ready, rd_data, rd_valid, rd_err, count, full, empty
  );

  modport slave (
    input  flush, wr_valid, wr_data, row_pop, rd_req, rd_mode, rd_offset,
    output wr_ready, rd_data, rd_valid, rd_err, count, full, empty
  );
endinterface

// File: rtl/ref_win_mem.sv
// ---------------------------------------------------------------------------
// ref_win_mem
//   Circular reference-window row buffer for integer motion estimation.
//   Rows arrive one per cycle from the reference fetch and are appended at
//   the tail; the oldest row sits at the head and is retired by row_pop.
//   Reads address rows relative to the oldest stored row and return either
//   one row or an NR-row burst with a fixed one-cycle latency.
//
//   Ports
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset
//     bus  slave modport of ref_win_mem_if (see that file for signals)
//
//   Parameters must match those of the connected ref_win_mem_if instance.
//   DEPTH must be a power of two and >= NR.
// ---------------------------------------------------------------------------
module ref_win_mem #(
  parameter int PIXEL = 8,
  parameter int X     = 32,
  parameter int DEPTH = 64,
  parameter int NR    = 8
) (
  input  logic          clk,
  input  logic          rst,
  ref_win_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = PIXEL * X;

  // Row storage and pointer state
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;

  // Registered read response
  logic [NR*RW-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;

  // Decoded per-cycle events
  logic             clear;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             pop_acc;
  logic [AW:0]      rd_len;
  logic [AW:0]      rd_end;
  logic             rd_ok;
  logic [NR*RW-1:0] rd_rows;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // rst wins over flush, flush wins over normal traffic; both drop any
  // same-cycle write, pop and read.
  assign clear   = rst || bus.flush;
  // wr_ready comes from the pre-pop count, so a write while full is refused
  // even when a pop frees a slot in the same cycle.
  assign wr_acc  = bus.wr_valid && !full && !clear;
  assign pop_acc = bus.row_pop && !empty && !clear;

  // Range check in AW+1 bits so a large offset cannot wrap back into range.
  // It uses the pre-update count: a row written this cycle is not yet
  // readable, a row popped this cycle still is.
  assign rd_len = bus.rd_mode ? (AW+1)'(NR) : (AW+1)'(1);
  assign rd_end = {1'b0, bus.rd_offset} + rd_len;
  assign rd_ok  = (rd_end <= count_q);

  // Gather rows starting at the pre-pop head; the AW-bit sum wraps modulo
  // DEPTH, which is the physical circular addressing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_rows = '0;
    for (int i = 0; i < NR; i++) begin
      if (i == 0 || bus.rd_mode) begin
        rd_rows[i*RW +: RW] = mem_q[head_q + bus.rd_offset + AW'(i)];
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;

    if (clear) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else begin
      if (wr_acc)  tail_d = tail_q + 1'b1;
      if (pop_acc) head_d = head_q + 1'b1;

      unique case ({wr_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Out-of-range reads leave rd_data holding its previous value.
      if (bus.rd_req) begin
        if (rd_ok) begin
          rd_data_d  = rd_rows;
          rd_valid_d = 1'b1;
        end else begin
          rd_err_d   = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    rd_data_q  <= rd_data_d;
    rd_valid_q <= rd_valid_d;
    rd_err_q   <= rd_err_d;
  end

  // NOTE: the row array has no reset; count gates every read, so stale
  // contents are never observable and clearing DEPTH rows would be wasted.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[tail_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = !full;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;

endmodule

// File: tb/tb_ref_win_mem.sv
// ---------------------------------------------------------------------------
// tb_ref_win_mem
//   Self-checking bench for ref_win_mem. A queue of rows (oldest first)
//   models the buffer; each cycle the expected read response is computed
//   from the queue before applying that cycle's pop and write, then every
//   output is compared one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_ref_win_mem;
  localparam int PIXEL = 8;
  localparam int X     = 32;
  localparam int DEPTH = 64;
  localparam int NR    = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = PIXEL * X;

  logic clk;
  logic rst;

  ref_win_mem_if #(.PIXEL(PIXEL), .X(X), .DEPTH(DEPTH), .NR(NR)) bus_if ();

  ref_win_mem #(.PIXEL(PIXEL), .X(X), .DEPTH(DEPTH), .NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [RW-1:0] model_q [$];
  logic [RW-1:0] exp_rows [NR];
  logic          exp_valid;
  logic          exp_err;

  task automatic check(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] fill_row(input logic [7:0] b);
    logic [RW-1:0] r;
    r = '0;
    for (int p = 0; p < RW / 8; p++) r[p*8 +: 8] = b;
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    r = '0;
    for (int w = 0; w < (RW + 31) / 32; w++) r = (r << 32) | RW'($urandom);
    return r;
  endfunction

  // One clock cycle: drive inputs, advance the model, step, compare.
  task automatic cyc(input logic r, input logic f, input logic wv,
                     input logic [RW-1:0] wd, input logic pop,
                     input logic rq, input logic md, input int off);
    int n;
    int sz;
    rst              = r;
    bus_if.flush     = f;
    bus_if.wr_valid  = wv;
    bus_if.wr_data   = wd;
    bus_if.row_pop   = pop;
    bus_if.rd_req    = rq;
    bus_if.rd_mode   = md;
    bus_if.rd_offset = AW'(off);

    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r || f) begin
      model_q.delete();
      for (int i = 0; i < NR; i++) exp_rows[i] = '0;
    end else begin
      sz = model_q.size();
      if (rq) begin
        n = md ? NR : 1;
        if (off + n <= sz) begin
          exp_valid = 1'b1;
          for (int i = 0; i < NR; i++)
            exp_rows[i] = (i < n) ? model_q[off + i] : '0;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (pop && sz > 0) void'(model_q.pop_front());
      if (wv && sz < DEPTH) model_q.push_back(wd);
    end

    @(posedge clk);
    #1;
    sz = model_q.size();
    check("count",    RW'(bus_if.count),    RW'(sz));
    check("full",     RW'(bus_if.full),     RW'(sz == DEPTH));
    check("empty",    RW'(bus_if.empty),    RW'(sz == 0));
    check("wr_ready", RW'(bus_if.wr_ready), RW'(sz != DEPTH));
    check("rd_valid", RW'(bus_if.rd_valid), RW'(exp_valid));
    check("rd_err",   RW'(bus_if.rd_err),   RW'(exp_err));
    for (int i = 0; i < NR; i++)
      check($sformatf("rd_row%0d", i), bus_if.rd_data[i*RW +: RW], exp_rows[i]);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic wr(input logic [RW-1:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic rd(input logic md, input int off);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, md, off);
  endtask

  task automatic do_flush();
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int wr_pct;
    int pop_pct;
    int rd_pct;
    int sz;
    int off;

    // Reset, then the basic ten-row window
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) wr(fill_row(8'(k)));
    rd(1'b1, 2);           // rows 2..9
    idle();                // rd_valid drops back to 0
    rd(1'b0, 9);           // single, last row
    rd(1'b1, 3);           // 3+8 > 10 -> rd_err, data held
    rd(1'b0, 10);          // single at count -> rd_err
    idle();

    // Fill to full, overflow attempt, pop 4, refill across the wrap
    do_flush();
    for (int k = 0; k < 64; k++) wr(fill_row(8'(k)));
    wr(fill_row(8'hEE));   // dropped, count stays 64
    // Write + pop while full: the write is still refused
    cyc(1'b0, 1'b0, 1'b1, fill_row(8'hDD), 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 64; k < 68; k++) wr(fill_row(8'(k)));
    rd(1'b1, 56);          // rows 0x3C..0x43, physical wrap 63->0
    rd(1'b1, 0);
    rd(1'b1, 63);          // large offset must not wrap into range

    // Same-cycle write/pop/read interactions at count 10
    do_flush();
    for (int k = 0; k < 10; k++) wr(fill_row(8'(8'h10 + k)));
    cyc(1'b0, 1'b0, 1'b1, fill_row(8'h1A), 1'b1, 1'b0, 1'b0, 0);
    rd(1'b1, 0);           // shows head and tail both moved
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 0);   // reads popped row
    cyc(1'b0, 1'b0, 1'b1, fill_row(8'h1B), 1'b0, 1'b1, 1'b0, 8); // old last row
    cyc(1'b0, 1'b0, 1'b1, fill_row(8'h1C), 1'b0, 1'b1, 1'b0, 10); // at count -> err
    rd(1'b1, 3);

    // Flush and reset in the middle of traffic
    cyc(1'b0, 1'b1, 1'b1, fill_row(8'h55), 1'b0, 1'b1, 1'b1, 0);
    idle();
    for (int k = 0; k < 12; k++) wr(rand_row());
    rd(1'b1, 1);
    rd(1'b1, 2);
    cyc(1'b1, 1'b0, 1'b1, rand_row(), 1'b1, 1'b1, 1'b1, 0);
    idle();

    // Randomized traffic with shifting write/pop/read mixes
    wr_pct = 70; pop_pct = 30; rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        wr_pct  = $urandom_range(10, 95);
        pop_pct = $urandom_range(5, 90);
        rd_pct  = $urandom_range(20, 90);
      end
      sz = model_q.size();
      if ($urandom_range(0, 3) == 0) off = $urandom_range(0, DEPTH - 1);
      else begin
        off = $urandom_range(0, sz);
        if (off > DEPTH - 1) off = DEPTH - 1;
      end
      cyc(($urandom_range(0, 599) == 0),
          ($urandom_range(0, 399) == 0),
          ($urandom_range(0, 99) < wr_pct),
          rand_row(),
          ($urandom_range(0, 99) < pop_pct),
          ($urandom_range(0, 99) < rd_pct),
          1'($urandom_range(0, 1)),
          off);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ref_win_mem.md
Name: ref_win_mem

Overview:
- Parametrised circular reference-window row buffer for the HEVC integer motion-estimation datapath.
- Stores search-window rows written one row per cycle from the external reference fetch.
- Serves single-row or NR-row burst reads, addressed relative to the oldest stored row, to the SAD array.
- Supports sliding-window retirement (pop) of the oldest row and a full flush at search start.

Parameters:
PIXEL, 8, bits per pixel
X, 32, pixels per row
DEPTH, 64, rows stored; power of two, >= NR
NR, 8, rows returned by a burst read
AW, log2(DEPTH), derived row-address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  clears buffer (same effect as rst on state)
wr_valid  in  1  row write request
wr_ready  out  1  !full
wr_data  in  PIXEL*X  row pixels, pixel 0 in LSBs
row_pop  in  1  retire oldest row
rd_req  in  1  read request
rd_mode  in  1  0 = single row, 1 = NR-row burst
rd_offset  in  AW  first row, relative to oldest stored row
rd_data  out  NR*PIXEL*X  read result
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_err  out  1  one-cycle pulse, read out of range
count  out  AW+1  rows stored
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State: head and tail pointers (AW bits), count (AW+1 bits), and a DEPTH x PIXEL*X register array.
- Priority: rst > flush > normal operation.
- Reset/flush: head=0, tail=0, count=0; rd_data=0, rd_valid=0, rd_err=0.
  - Array contents are not cleared.
  - Same-cycle write, pop and read are dropped; no rd_valid or rd_err follows.
- Write: accepted when wr_valid && wr_ready.
  - mem[tail] <= wr_data; tail <= tail+1, wrapping modulo DEPTH.
- Pop: accepted when row_pop && !empty; head <= head+1, wrapping. Pop when empty is ignored.
- count update: +1 on write only, -1 on pop only, unchanged when both are accepted.
  - Write while full is not accepted even if a pop occurs the same cycle, because wr_ready is derived from the pre-pop count.
- Read request accepted in cycle T; n = 1 if rd_mode=0, NR if rd_mode=1.
- Range check against pre-update state of cycle T:
  - A row written in T is not readable.
  - A row popped in T is still readable.
  - Physical addresses use the pre-pop head.
- If rd_offset + n <= count: row i (0..n-1) = mem[(head + rd_offset + i) mod DEPTH].
  - Row i is placed at rd_data[(i+1)*PIXEL*X-1 : i*PIXEL*X].
  - In single mode, rows 1..NR-1 are zero.
  - rd_valid=1 at T+1.
- Otherwise: rd_err=1 at T+1, rd_valid=0, rd_data holds its previous value.
- Read latency is exactly 1 cycle; back-to-back requests every cycle are supported; there is no read backpressure.
- rd_valid and rd_err are never high together and are 0 in any cycle not following an accepted request.
- The offset sum is computed in AW+1 bits, so an offset near DEPTH cannot wrap into range.
- wr_ready, full, empty and count are combinational from registered state.
  - After reset: wr_ready=1, empty=1, full=0, count=0.

Test Plan:
- Reset then write rows k=0..9, each row all bytes = k -> count=10. Burst at rd_offset=2 -> rd_valid at T+1; row i bytes = 2+i for i=0..7; rd_err=0.
- Single read at rd_offset=9 -> row0 bytes = 0x09, upper 7 rows zero. Burst at rd_offset=3 with count=10 -> rd_err pulse, rd_valid=0, rd_data unchanged.
- Fill 64 rows -> full=1, wr_ready=0; extra write is dropped and count stays 64. Pop 4 rows, write rows 64..67 (bytes 0x40..0x43), burst at rd_offset=56 -> rows 0x3C..0x43, crossing the physical wrap 63->0.
- Same-cycle write and pop at count=10 -> count stays 10, head and tail both advance. Same-cycle read at rd_offset=0 with pop -> returns the row being popped.
- Same-cycle read at rd_offset=count-1 in single mode with a write -> valid, and returns the old last row, not the new one. A single read at rd_offset=count in that same cycle -> rd_err.
- Flush asserted with wr_valid and rd_req mid-stream -> count=0, empty=1, no rd_valid or rd_err next cycle. Assert rst mid-burst stream -> all outputs at reset values the next cycle.
